word_access_sequencer: RTL and testbench
========================================

# word_access_sequencer

Sequences 32-bit word reads and writes onto a single byte-wide synchronous RAM port, issuing four byte beats per word in big-endian order. Two requesters share that port: port 0 is the read-only instruction-fetch side and port 1 is the load/store side. Round-robin arbitration decides which of them is served. The block sits between the processor's memory stage and one port of the true dual-port byte RAM, so the processor only ever sees whole words.

## Interface
- `ADDR_W`, default 16: RAM byte-address width. Only `addr[ADDR_W-1:0]` is used.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  fetch request.
- `req0_addr`  in  32  fetch byte address.
- `req0_ready`  out  1  fetch accepted this cycle.
- `req0_done`  out  1  one-cycle pulse: fetch complete.
- `req0_rdata`  out  32  fetched word, valid from `done` until the next port-0 completion.
- `req1_valid`  in  1  load/store request.
- `req1_write`  in  1  1 = store, 0 = load.
- `req1_addr`  in  32  load/store byte address.
- `req1_wdata`  in  32  store data.
- `req1_ready`  out  1  load/store accepted this cycle.
- `req1_done`  out  1  one-cycle completion pulse.
- `req1_rdata`  out  32  loaded word, held until the next port-1 load completion.
- `busy`  out  1  a sequence is in progress (state ≠ IDLE).
- `ram_addr`  out  ADDR_W  RAM byte address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  8  RAM write byte.
- `ram_rdata`  in  8  RAM read byte. It is registered, so it is valid the cycle after its address is presented.

## Operation
- **States:** IDLE, BEAT, DRAIN, RESP.
  - A 2-bit beat counter `cnt` selects the beat.
  - Latched at accept: base address, `wdata`, `write`, and the granted port.
- **IDLE**
  - `reqN_ready = (state==IDLE) && grantN`; this is combinational and asserted only when `reqN_valid` is high.
  - A handshake (valid & ready) latches the request and moves to BEAT with `cnt=0`.
  - A requester may drop `valid` before it is accepted.
- **Arbitration**
  - A lone valid requester wins immediately.
  - On a tie, the port not granted last wins.
  - The last-grant register resets to 1, so port 0 wins the first tie.
- **BEAT**
  - `ram_addr = base + cnt`, computed modulo 2^ADDR_W (wraps around).
  - Unaligned addresses are legal.
  - Byte lanes: beat 0 is `[31:24]`, beat 1 is `[23:16]`, beat 2 is `[15:8]`, beat 3 is `[7:0]`.
- **Write**
  - `ram_we=1` and `ram_wdata` = lane `cnt` on every beat.
  - After `cnt=3`, go to RESP.
- **Read**
  - `ram_we=0` throughout.
  - In BEAT with `cnt≥1`, capture `ram_rdata` into lane `cnt-1`.
  - After `cnt=3`, go to DRAIN, which captures lane 3 and then goes to RESP.
- **RESP**
  - The granted port's `done=1` for exactly one cycle.
  - For a read, that port's `rdata` is updated from the capture register in the same cycle.
  - The next state is IDLE.
- Port 0 ignores any write intent; it is read-only by construction.
- **Reset (asynchronous, including mid-sequence):**
  - state=IDLE, `cnt=0`.
  - `ram_we=0`, `ram_addr=0`, `ram_wdata=0`.
  - `done=0`, `rdata=0`, `busy=0`, last-grant=1.
  - A partially written word is not restored.

## Timing
- Accept at cycle T.
- **Read:** beats at T+1..T+4, DRAIN at T+5, `done` and valid `rdata` at T+6. Seven cycles per word.
- **Write:** `ram_we` high at T+1..T+4, `done` at T+5. Six cycles per word.
- The next accept is possible in the cycle after RESP; requests are not pipelined.
- `ram_*` outputs are registered or decoded from registered state only. There is no combinational path from `req*` to `ram_*`.
- `ready` is the only combinational output that depends on `valid`.

## Structure
- The shared package `antares_mem_pkg` holds:
  - the state enum;
  - `BEATS=4`;
  - the lane-select function (cnt → bit range).
- One sub-module, `rr_arbiter2`: two requests in, one-hot grant out, plus the last-grant register, with an update strobe on accept.

## Test plan
- **Load:** RAM[0x0010..0x0013] = DE AD BE EF; port 1 load at 0x0010. Expect `ram_addr` 0x0010..0x0013 at T+1..T+4, `req1_done` at T+6, `req1_rdata` = 0xDEADBEEF.
- **Store then load:** port 1 store of 0x12345678 to 0x0100. Expect `ram_we` high at T+1..T+4 with bytes 12, 34, 56, 78, and `done` at T+5. A following load returns 0x12345678.
- **Arbitration:** both ports valid in the first cycle after reset. Port 0 is granted first and port 1 is accepted in the IDLE cycle after port 0's RESP. On the next tie, port 0 wins again.
- **Wrap-around:** port 0 fetch at 0xABCDFFFE with `ADDR_W`=16. Expect `ram_addr` FFFE, FFFF, 0000, 0001; the upper address bits are ignored.
- **Reset mid-sequence:** assert `rst_n` low during write beat 2. `ram_we` drops without waiting for a clock edge, no `done` pulses, `busy`=0. After release, a valid request sees `ready` in the first cycle.
- **Read isolation:** port 0 and port 1 alternate reads. Each `rdata` changes only on its own `done` pulse, and `ram_we` stays 0 throughout.

Source files
------------

// File: rtl/antares_mem_pkg.sv
// Shared types and helpers for the byte-serial word access sequencer.
package antares_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_DRAIN,
    ST_RESP
  } state_t;

  localparam int unsigned BEATS = 4;

  // Big-endian lane: beat 0 maps to [31:24], beat 3 to [7:0].
  function automatic logic [4:0] lane_lsb(input logic [1:0] cnt);
    return {~cnt, 3'b000};
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] cnt);
    return w[lane_lsb(cnt) +: 8];
  endfunction

endpackage

// File: rtl/word_access_sequencer_if.sv
// Requester handshakes and byte RAM port of the word access sequencer.
interface word_access_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              req0_valid;
  logic [31:0]       req0_addr;
  logic              req0_ready;
  logic              req0_done;
  logic [31:0]       req0_rdata;
  logic              req1_valid;
  logic              req1_write;
  logic [31:0]       req1_addr;
  logic [31:0]       req1_wdata;
  logic              req1_ready;
  logic              req1_done;
  logic [31:0]       req1_rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  modport slave (
    input  req0_valid, req0_addr,
    output req0_ready, req0_done, req0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req1_ready, req1_done, req1_rdata,
    output busy, ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req0_valid, req0_addr,
    input  req0_ready, req0_done, req0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req1_ready, req1_done, req1_rdata,
    input  busy, ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/word_access_sequencer_arb.sv
// Two-way round-robin arbiter; remembers the last granted port across accepts.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);
  logic last;

  always_comb begin
    grant[0] = req[0] && (!req[1] ||  last);
    grant[1] = req[1] && (!req[0] || !last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= 1'b1;
    else if (update) last <= grant[1];
  end
endmodule

// File: rtl/word_access_sequencer.sv
// Serialises 32-bit word reads/writes from two requesters onto a byte-wide RAM port.
module word_access_sequencer #(
  parameter int ADDR_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  word_access_sequencer_if.slave bus
);
  import antares_mem_pkg::*;

  state_t            state;
  logic [1:0]        cnt;
  logic [31:0]       wdata_q;
  logic [31:0]       cap;
  logic              wr_q;
  logic              port_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [7:0]        ram_wdata_q;
  logic              done0_q, done1_q;
  logic [31:0]       rdata0_q, rdata1_q;

  logic [1:0]        grant;
  logic              accept;
  logic              acc_wr;
  logic [31:0]       acc_addr;
  logic              unused_addr_bits;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({bus.req1_valid, bus.req0_valid}),
    .update (accept),
    .grant  (grant)
  );

  always_comb begin
    bus.req0_ready = (state == ST_IDLE) && grant[0];
    bus.req1_ready = (state == ST_IDLE) && grant[1];
    accept         = (state == ST_IDLE) && (grant != 2'b00);
    acc_wr         = grant[1] && bus.req1_write;
    acc_addr       = grant[1] ? bus.req1_addr : bus.req0_addr;
  end

  assign unused_addr_bits = ^acc_addr[31:ADDR_W];

  assign bus.busy       = (state != ST_IDLE);
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.req0_done  = done0_q;
  assign bus.req1_done  = done1_q;
  assign bus.req0_rdata = rdata0_q;
  assign bus.req1_rdata = rdata1_q;

  // RAM outputs are loaded one beat ahead so they are pure registers;
  // the address register itself walks base+cnt and wraps at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wdata_q     <= '0;
      cap         <= '0;
      wr_q        <= 1'b0;
      port_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            port_q      <= grant[1];
            wr_q        <= acc_wr;
            wdata_q     <= bus.req1_wdata;
            ram_addr_q  <= acc_addr[ADDR_W-1:0];
            ram_we_q    <= acc_wr;
            ram_wdata_q <= acc_wr ? lane_byte(bus.req1_wdata, 2'd0) : '0;
            cnt         <= '0;
            state       <= ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (!wr_q && cnt != 2'd0) cap[lane_lsb(cnt - 2'd1) +: 8] <= bus.ram_rdata;
          if (cnt == 2'(BEATS - 1)) begin
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cnt         <= '0;
            if (wr_q) begin
              done0_q <= !port_q;
              done1_q <= port_q;
              state   <= ST_RESP;
            end else begin
              state   <= ST_DRAIN;
            end
          end else begin
            cnt        <= cnt + 2'd1;
            ram_addr_q <= ram_addr_q + ADDR_W'(1);
            if (wr_q) ram_wdata_q <= lane_byte(wdata_q, cnt + 2'd1);
          end
        end
        ST_DRAIN: begin
          cap[7:0] <= bus.ram_rdata;
          if (port_q) rdata1_q <= {cap[31:8], bus.ram_rdata};
          else        rdata0_q <= {cap[31:8], bus.ram_rdata};
          done0_q <= !port_q;
          done1_q <= port_q;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_access_sequencer.sv
// Directed bench for word_access_sequencer with a registered byte RAM model.
module tb_word_access_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_access_sequencer_if #(.ADDR_W(16)) bus ();

  word_access_sequencer #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  mem [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;

  always @(posedge clk) begin
    if (pre_we)          mem[pre_addr] <= pre_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_rd [2];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_write = 1'b0;
    bus.req1_addr  = '0;
    bus.req1_wdata = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_we"},     32'(bus.ram_we), 32'd0);
    check({tag, "_addr"},   32'(bus.ram_addr), 32'd0);
    check({tag, "_wdata"},  32'(bus.ram_wdata), 32'd0);
    check({tag, "_done0"},  32'(bus.req0_done), 32'd0);
    check({tag, "_done1"},  32'(bus.req1_done), 32'd0);
    check({tag, "_rdata0"}, bus.req0_rdata, 32'd0);
    check({tag, "_rdata1"}, bus.req1_rdata, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_reset_state("rst");
    tick();
    rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  function automatic logic [31:0] done_of(input int p);
    return 32'(p == 0 ? bus.req0_done : bus.req1_done);
  endfunction

  function automatic logic [31:0] rdata_of(input int p);
    return p == 0 ? bus.req0_rdata : bus.req1_rdata;
  endfunction

  // Full read on port p; also checks the other port's rdata never moves.
  task automatic read_word(input int p, input logic [31:0] addr, input logic [31:0] exp,
                           input string tag);
    logic [15:0] a;
    a = addr[15:0];
    if (p == 0) begin bus.req0_valid = 1'b1; bus.req0_addr = addr; end
    else begin bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = addr; end
    #1;
    check({tag, "_ready"}, 32'(p == 0 ? bus.req0_ready : bus.req1_ready), 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_addr"}, 32'(bus.ram_addr), 32'(16'(a + 16'(i))));
      check({tag, "_we"}, 32'(bus.ram_we), 32'd0);
      check({tag, "_other_rd"}, rdata_of(1 - p), exp_rd[1 - p]);
      tick();
    end
    check({tag, "_drain_done"}, done_of(p), 32'd0);
    check({tag, "_drain_rd"}, rdata_of(p), exp_rd[p]);
    tick();
    check({tag, "_done"}, done_of(p), 32'd1);
    check({tag, "_other_done"}, done_of(1 - p), 32'd0);
    check({tag, "_rdata"}, rdata_of(p), exp);
    check({tag, "_other_rd"}, rdata_of(1 - p), exp_rd[1 - p]);
    exp_rd[p] = exp;
    tick();
    check({tag, "_done_end"}, done_of(p), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input string tag);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    bus.req1_valid = 1'b1;
    bus.req1_write = 1'b1;
    bus.req1_addr  = addr;
    bus.req1_wdata = wdata;
    #1;
    check({tag, "_ready"}, 32'(bus.req1_ready), 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    bus.req1_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_we"}, 32'(bus.ram_we), 32'd1);
      check({tag, "_addr"}, 32'(bus.ram_addr), addr[15:0] + 32'(i));
      check({tag, "_byte"}, 32'(bus.ram_wdata), 32'(bytes[i]));
      check({tag, "_early_done"}, 32'(bus.req1_done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(bus.req1_done), 32'd1);
    check({tag, "_we_off"}, 32'(bus.ram_we), 32'd0);
    tick();
    check({tag, "_done_end"}, 32'(bus.req1_done), 32'd0);
  endtask

  initial begin
    idle_inputs();
    bus.ram_rdata = '0;
    rst_n = 1'b0;
    tick();
    poke(16'h0010, 8'hDE); poke(16'h0011, 8'hAD);
    poke(16'h0012, 8'hBE); poke(16'h0013, 8'hEF);
    poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22);
    poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);
    poke(16'h0200, 8'h00); poke(16'h0201, 8'h00);
    poke(16'h0202, 8'h5A); poke(16'h0203, 8'h77);
    do_reset();

    // Load, store, load-back
    read_word(1, 32'h0000_0010, 32'hDEAD_BEEF, "load");
    write_word(32'h0000_0100, 32'h1234_5678, 8'h12, 8'h34, 8'h56, 8'h78, "store");
    read_word(1, 32'h0000_0100, 32'h1234_5678, "loadback");

    // Arbitration from reset: tie goes to port 0, then port 1, then port 0 again
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 32'h0000_0010;
    bus.req1_valid = 1'b1; bus.req1_write = 1'b0; bus.req1_addr = 32'h0000_0100;
    #1;
    check("arb_tie1_r0", 32'(bus.req0_ready), 32'd1);
    check("arb_tie1_r1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    repeat (5) tick();
    check("arb_p0_done", 32'(bus.req0_done), 32'd1);
    check("arb_p0_rdata", bus.req0_rdata, 32'hDEAD_BEEF);
    check("arb_p1_wait", 32'(bus.req1_ready), 32'd0);
    tick();
    check("arb_p1_ready", 32'(bus.req1_ready), 32'd1);
    check("arb_p0_notready", 32'(bus.req0_ready), 32'd0);
    tick();
    bus.req0_valid = 1'b1;
    repeat (5) tick();
    check("arb_p1_done", 32'(bus.req1_done), 32'd1);
    check("arb_p1_rdata", bus.req1_rdata, 32'h1234_5678);
    check("arb_p0_hold", bus.req0_rdata, 32'hDEAD_BEEF);
    tick();
    check("arb_tie2_r0", 32'(bus.req0_ready), 32'd1);
    check("arb_tie2_r1", 32'(bus.req1_ready), 32'd0);
    idle_inputs();
    exp_rd[0] = 32'hDEAD_BEEF;
    exp_rd[1] = 32'h1234_5678;
    tick();

    // Wrap-around with upper address bits ignored
    read_word(0, 32'hABCD_FFFE, 32'h1122_3344, "wrap");

    // Alternating reads
    read_word(1, 32'h0000_FFFE, 32'h1122_3344, "iso1");
    read_word(0, 32'h0000_0100, 32'h1234_5678, "iso2");
    read_word(1, 32'h0000_0010, 32'hDEAD_BEEF, "iso3");
    read_word(0, 32'h0000_0010, 32'hDEAD_BEEF, "iso4");

    // Reset during write beat 2
    bus.req1_valid = 1'b1; bus.req1_write = 1'b1;
    bus.req1_addr = 32'h0000_0200; bus.req1_wdata = 32'hAABB_CCDD;
    tick();
    idle_inputs();
    tick();
    tick();
    check("mid_we_beat2", 32'(bus.ram_we), 32'd1);
    check("mid_addr_beat2", 32'(bus.ram_addr), 32'h0000_0202);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    tick();
    check("mid_rst_done0", 32'(bus.req0_done), 32'd0);
    check("mid_rst_done1", 32'(bus.req1_done), 32'd0);
    #2;
    rst_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    check("mid_mem0", 32'(mem[16'h0200]), 32'h0000_00AA);
    check("mid_mem1", 32'(mem[16'h0201]), 32'h0000_00BB);
    check("mid_mem2", 32'(mem[16'h0202]), 32'h0000_005A);
    check("mid_mem3", 32'(mem[16'h0203]), 32'h0000_0077);
    read_word(0, 32'h0000_0010, 32'hDEAD_BEEF, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
